pc_fetch: RTL

//  Program counter and instruction-fetch sequencer for the N-queen core.

---
 rtl/pc_fetch_pkg.sv | 14 +
 rtl/pc_fetch_if.sv | 41 ++++
 rtl/pc_fetch_pc_reg.sv | 32 +++
 rtl/pc_fetch.sv | 112 +++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared widths and fetch-FSM encodings
// for the N-queen core program counter / fetch unit.
package pc_fetch_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int INST_W_DEF = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: jump input, imem req/ack bus and
// decoder valid/ready bus of the fetch unit.
interface pc_fetch_if
   import pc_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INST_W = INST_W_DEF
);

   logic              pc_we;
   logic [ADDR_W-1:0] pc_in;
   logic              halt;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_data;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic              halted;

   modport master (
      input  pc_we, pc_in, halt,
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      output inst, inst_pc, inst_valid,
      input  inst_ready,
      output halted
   );

   modport slave (
      output pc_we, pc_in, halt,
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      input  inst, inst_pc, inst_valid,
      output inst_ready,
      input  halted
   );

endinterface

// File: rtl/pc_fetch_pc_reg.sv
// pc_fetch_pc_reg: next-pc mux (jump / +1 / hold) and
// async-reset pc register, shared with the debug stepper.
module pc_fetch_pc_reg #(
   parameter int                ADDR_W   = 6,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;

   // wraps modulo 2^ADDR_W
   always_comb begin
      pc_d = pc;
      unique case (1'b1)
         load:    pc_d = pc_in;
         inc:     pc_d = pc + ADDR_W'(1);
         default: pc_d = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc <= RESET_PC;
      else      pc <= pc_d;
   end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch sequencer,
// imem req/ack on one side, decoder valid/ready on the other.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INST_W   = INST_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic        clk,
   input logic        rst,
   pc_fetch_if.master bus
);

   logic [2:0]        state;
   logic [2:0]        state_d;
   logic              flush;
   logic              flush_d;
   logic              load;
   logic              inc;
   logic              cap;
   logic              jump;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addr_q;
   logic [INST_W-1:0] inst_q;
   logic [ADDR_W-1:0] inst_pc_q;

   pc_fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .inc   (inc),
      .pc_in (bus.pc_in),
      .pc    (pc)
   );

   assign jump = bus.pc_we;

   always_comb begin
      state_d = state;
      flush_d = flush;
      load    = 1'b0;
      inc     = 1'b0;
      cap     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            state_d = ST_FETCH;
            load    = jump;
         end
         ST_FETCH: begin
            // request already issued: finish it, then refetch
            state_d = ST_WAIT;
            load    = jump;
            if (jump) flush_d = 1'b1;
         end
         ST_WAIT: begin
            load = jump;
            if (bus.imem_ack) begin
               flush_d = 1'b0;
               cap     = !(flush || jump);
               inc     = !(flush || jump);
               state_d = (flush || jump) ? ST_FETCH : ST_HOLD;
            end else if (jump) begin
               flush_d = 1'b1;
            end
         end
         ST_HOLD: begin
            load = jump;
            if (jump || bus.inst_ready) state_d = ST_FETCH;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
      if (bus.halt && state != ST_IDLE && state != ST_HALTED) begin
         state_d = ST_HALTED;
         flush_d = 1'b0;
         load    = 1'b0;
         inc     = 1'b0;
         cap     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         flush     <= 1'b0;
         addr_q    <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state <= state_d;
         flush <= flush_d;
         if (state == ST_FETCH) addr_q <= pc;
         if (cap) begin
            inst_q    <= bus.imem_data;
            inst_pc_q <= addr_q;
         end
      end
   end

   assign bus.imem_req   = (state == ST_FETCH) || (state == ST_WAIT);
   assign bus.imem_addr  = (state == ST_FETCH) ? pc :
                           (state == ST_WAIT)  ? addr_q : '0;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.inst_valid = (state == ST_HOLD);
   assign bus.halted     = (state == ST_HALTED);

endmodule
